// File: rtl/multi_port_rob.sv
// Multi-port reorder buffer: in-order allocation, out-of-order CDB writeback with
// operand bypass, up to two in-order commits per cycle, and mispredict flush.
module multi_port_rob #(
  parameter int  DEPTH       = 16,
  parameter int  NUM_CDB     = 2,
  parameter int  COMMIT_W    = 2,
  parameter int  FULL_MARGIN = 2,
  localparam int IDW         = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    alloc_en,
  input  logic [4:0]              alloc_rd,
  output logic [IDW-1:0]          alloc_id,
  output logic                    full,
  input  logic [NUM_CDB-1:0]      cdb_valid,
  input  logic [NUM_CDB*IDW-1:0]  cdb_id,
  input  logic [NUM_CDB*32-1:0]   cdb_data,
  input  logic [NUM_CDB-1:0]      cdb_jump,
  input  logic [NUM_CDB*32-1:0]   cdb_tpc,
  input  logic [IDW-1:0]          q1_id,
  input  logic [IDW-1:0]          q2_id,
  output logic                    q1_ready,
  output logic                    q2_ready,
  output logic [31:0]             q1_data,
  output logic [31:0]             q2_data,
  output logic [COMMIT_W-1:0]     cmt_valid,
  output logic [COMMIT_W*5-1:0]   cmt_rd,
  output logic [COMMIT_W*IDW-1:0] cmt_id,
  output logic [COMMIT_W*32-1:0]  cmt_data,
  output logic                    flush,
  output logic [31:0]             flush_pc
);
  localparam int SW = IDW - 1;
  typedef logic [SW-1:0] slot_t;

  logic [DEPTH-1:0] busy_q, ready_q, jump_q;
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      tpc_q  [DEPTH];
  logic [4:0]       rd_q   [DEPTH];

  slot_t          head, tail, h0, h1;
  logic [IDW-1:0] count, count_next;
  logic [1:0]     cmt_go;
  logic           alloc_ok, flush_next;
  logic [31:0]    flush_pc_next;

  // Ids are slot + 1 so that id 0 can mean "no producer".
  function automatic slot_t id_slot(input logic [IDW-1:0] id);
    return slot_t'(id - IDW'(1));
  endfunction

  // A result on the CDB this cycle overrides stored state; higher channels win.
  function automatic logic [32:0] query(input logic [IDW-1:0] id);
    logic [32:0] r;
    r = '0;
    if (id != '0) begin
      r = {ready_q[id_slot(id)], data_q[id_slot(id)]};
      for (int c = 0; c < NUM_CDB; c++)
        if (cdb_valid[c] && cdb_id[c*IDW +: IDW] == id) r = {1'b1, cdb_data[c*32 +: 32]};
    end
    return r;
  endfunction

  assign h0       = head;
  assign h1       = head + slot_t'(1);
  assign alloc_id = {1'b0, tail} + IDW'(1);
  assign full     = count > IDW'(DEPTH - FULL_MARGIN);
  assign alloc_ok = alloc_en && (count != IDW'(DEPTH));

  always_comb {q1_ready, q1_data} = query(q1_id);
  always_comb {q2_ready, q2_data} = query(q2_id);

  // The second commit slot never retires past a redirecting head entry.
  always_comb begin
    cmt_go    = '0;
    cmt_go[0] = busy_q[h0] && ready_q[h0];
    if (COMMIT_W == 2)
      cmt_go[1] = cmt_go[0] && busy_q[h1] && ready_q[h1] && !jump_q[h0];
    flush_next    = (cmt_go[0] && jump_q[h0]) || (cmt_go[1] && jump_q[h1]);
    flush_pc_next = (cmt_go[0] && jump_q[h0]) ? tpc_q[h0] : tpc_q[h1];
    count_next    = count + IDW'(alloc_ok) - IDW'(cmt_go[0]) - IDW'(cmt_go[1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      busy_q    <= '0;
      ready_q   <= '0;
      jump_q    <= '0;
      // NOTE: the entry payload arrays are cleared too because reset must leave no stale entry contents behind.
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        tpc_q[i]  <= '0;
        rd_q[i]   <= '0;
      end
      cmt_valid <= '0;
      cmt_rd    <= '0;
      cmt_id    <= '0;
      cmt_data  <= '0;
      flush     <= 1'b0;
      flush_pc  <= '0;
    end else if (flush) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      busy_q    <= '0;
      ready_q   <= '0;
      jump_q    <= '0;
      cmt_valid <= '0;
      flush     <= 1'b0;
    end else if (!rdy) begin
      cmt_valid <= '0;
    end else begin
      cmt_valid <= '0;
      for (int c = 0; c < NUM_CDB; c++) begin
        if (cdb_valid[c] && cdb_id[c*IDW +: IDW] != '0 && busy_q[id_slot(cdb_id[c*IDW +: IDW])]) begin
          ready_q[id_slot(cdb_id[c*IDW +: IDW])] <= 1'b1;
          jump_q[id_slot(cdb_id[c*IDW +: IDW])]  <= cdb_jump[c];
          data_q[id_slot(cdb_id[c*IDW +: IDW])]  <= cdb_data[c*32 +: 32];
          tpc_q[id_slot(cdb_id[c*IDW +: IDW])]   <= cdb_tpc[c*32 +: 32];
        end
      end
      if (cmt_go[0]) begin
        busy_q[h0]        <= 1'b0;
        ready_q[h0]       <= 1'b0;
        cmt_valid[0]      <= 1'b1;
        cmt_rd[4:0]       <= rd_q[h0];
        cmt_id[IDW-1:0]   <= {1'b0, h0} + IDW'(1);
        cmt_data[31:0]    <= data_q[h0];
      end
      if (cmt_go[1]) begin
        busy_q[h1]                    <= 1'b0;
        ready_q[h1]                   <= 1'b0;
        cmt_valid[COMMIT_W-1]         <= 1'b1;
        cmt_rd[COMMIT_W*5-1 -: 5]     <= rd_q[h1];
        cmt_id[COMMIT_W*IDW-1 -: IDW] <= {1'b0, h1} + IDW'(1);
        cmt_data[COMMIT_W*32-1 -: 32] <= data_q[h1];
      end
      head <= head + slot_t'(cmt_go[0]) + slot_t'(cmt_go[1]);
      if (alloc_ok) begin
        busy_q[tail]  <= 1'b1;
        ready_q[tail] <= 1'b0;
        jump_q[tail]  <= 1'b0;
        data_q[tail]  <= '0;
        rd_q[tail]    <= alloc_rd;
        tail          <= tail + slot_t'(1);
      end
      count <= count_next;
      flush <= flush_next;
      if (flush_next) flush_pc <= flush_pc_next;
    end
  end
endmodule

// File: tb/tb_multi_port_rob.sv
// Self-checking bench for multi_port_rob: directed scenarios plus randomized
// traffic checked against an in-order queue model of the reorder buffer.
module tb_multi_port_rob;
  localparam int D = 16, NC = 2, CW = 2, FM = 2, IDW = 5;
  localparam int SD = 4, SIDW = 3;

  logic clk = 1'b0;
  logic rst, rdy;
  logic alloc_en; logic [4:0] alloc_rd; logic [IDW-1:0] alloc_id; logic full;
  logic [NC-1:0] cdb_valid, cdb_jump; logic [NC*IDW-1:0] cdb_id; logic [NC*32-1:0] cdb_data, cdb_tpc;
  logic [IDW-1:0] q1_id, q2_id; logic q1_ready, q2_ready; logic [31:0] q1_data, q2_data;
  logic [CW-1:0] cmt_valid; logic [CW*5-1:0] cmt_rd; logic [CW*IDW-1:0] cmt_id; logic [CW*32-1:0] cmt_data;
  logic flush; logic [31:0] flush_pc;

  logic s_alloc_en; logic [4:0] s_alloc_rd; logic [SIDW-1:0] s_alloc_id; logic s_full;
  logic [0:0] s_cdb_valid, s_cdb_jump; logic [SIDW-1:0] s_cdb_id; logic [31:0] s_cdb_data, s_cdb_tpc;
  logic [SIDW-1:0] s_q1_id, s_q2_id; logic s_q1_ready, s_q2_ready; logic [31:0] s_q1_data, s_q2_data;
  logic [0:0] s_cmt_valid; logic [4:0] s_cmt_rd; logic [SIDW-1:0] s_cmt_id; logic [31:0] s_cmt_data;
  logic s_flush; logic [31:0] s_flush_pc;

  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  multi_port_rob #(.DEPTH(D), .NUM_CDB(NC), .COMMIT_W(CW), .FULL_MARGIN(FM)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .alloc_en(alloc_en), .alloc_rd(alloc_rd), .alloc_id(alloc_id),
    .full(full), .cdb_valid(cdb_valid), .cdb_id(cdb_id), .cdb_data(cdb_data), .cdb_jump(cdb_jump),
    .cdb_tpc(cdb_tpc), .q1_id(q1_id), .q2_id(q2_id), .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_data(q1_data), .q2_data(q2_data), .cmt_valid(cmt_valid), .cmt_rd(cmt_rd), .cmt_id(cmt_id),
    .cmt_data(cmt_data), .flush(flush), .flush_pc(flush_pc));

  multi_port_rob #(.DEPTH(SD), .NUM_CDB(1), .COMMIT_W(1), .FULL_MARGIN(2)) dut_s (
    .clk(clk), .rst(rst), .rdy(rdy), .alloc_en(s_alloc_en), .alloc_rd(s_alloc_rd), .alloc_id(s_alloc_id),
    .full(s_full), .cdb_valid(s_cdb_valid), .cdb_id(s_cdb_id), .cdb_data(s_cdb_data), .cdb_jump(s_cdb_jump),
    .cdb_tpc(s_cdb_tpc), .q1_id(s_q1_id), .q2_id(s_q2_id), .q1_ready(s_q1_ready), .q2_ready(s_q2_ready),
    .q1_data(s_q1_data), .q2_data(s_q2_data), .cmt_valid(s_cmt_valid), .cmt_rd(s_cmt_rd), .cmt_id(s_cmt_id),
    .cmt_data(s_cmt_data), .flush(s_flush), .flush_pc(s_flush_pc));

  // Reference model: the ROB is an ordered queue of live entries, oldest first.
  typedef struct { int id; logic [4:0] rd; bit ready; logic [31:0] data; bit jump; logic [31:0] tpc; } ent_t;
  ent_t mq[$];
  int m_next_id;
  logic [1:0] m_cv;
  int m_id [2];
  logic [4:0] m_rd [2];
  logic [31:0] m_data [2];
  bit m_flush;
  logic [31:0] m_flush_pc;

  task automatic model_step();
    bit c0, c1, nf, aok;
    logic [31:0] npc;
    int tid;
    ent_t e;
    if (rst) begin
      mq.delete(); m_next_id = 1; m_cv = '0; m_flush = 0; m_flush_pc = '0;
      for (int k = 0; k < 2; k++) begin m_id[k] = 0; m_rd[k] = '0; m_data[k] = '0; end
      return;
    end
    if (m_flush) begin mq.delete(); m_next_id = 1; m_cv = '0; m_flush = 0; return; end
    if (!rdy) begin m_cv = '0; return; end
    c0 = mq.size() > 0 && mq[0].ready;
    c1 = c0 && mq.size() > 1 && mq[1].ready && !mq[0].jump;
    m_cv = {c1, c0};
    nf = 0; npc = '0;
    for (int k = 0; k < 2; k++)
      if (m_cv[k]) begin
        m_id[k] = mq[k].id; m_rd[k] = mq[k].rd; m_data[k] = mq[k].data;
        if (mq[k].jump) begin nf = 1; npc = mq[k].tpc; end
      end
    for (int c = 0; c < NC; c++) begin
      tid = int'(cdb_id[c*IDW +: IDW]);
      if (cdb_valid[c] && tid != 0)
        foreach (mq[i])
          if (mq[i].id == tid) begin
            mq[i].ready = 1; mq[i].data = cdb_data[c*32 +: 32];
            mq[i].jump = cdb_jump[c]; mq[i].tpc = cdb_tpc[c*32 +: 32];
          end
    end
    aok = alloc_en && mq.size() < D;
    repeat (int'(c0) + int'(c1)) void'(mq.pop_front());
    if (aok) begin
      e.id = m_next_id; e.rd = alloc_rd; e.ready = 0; e.data = '0; e.jump = 0; e.tpc = '0;
      mq.push_back(e);
      m_next_id = m_next_id % D + 1;
    end
    m_flush = nf;
    if (nf) m_flush_pc = npc;
  endtask

  // Returns {data_is_defined, ready, data}; a non-live entry's stale data is unspecified.
  function automatic logic [33:0] model_query(logic [IDW-1:0] qid);
    logic [33:0] r;
    r = '0;
    if (qid == '0) return {1'b1, 1'b0, 32'h0};
    foreach (mq[i]) if (mq[i].id == int'(qid) && mq[i].ready) r = {1'b1, 1'b1, mq[i].data};
    for (int c = 0; c < NC; c++)
      if (cdb_valid[c] && cdb_id[c*IDW +: IDW] == qid) r = {1'b1, 1'b1, cdb_data[c*32 +: 32]};
    return r;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_en = 0; alloc_rd = '0; cdb_valid = '0; cdb_id = '0; cdb_data = '0; cdb_jump = '0; cdb_tpc = '0;
    q1_id = '0; q2_id = '0;
    s_alloc_en = 0; s_alloc_rd = '0; s_cdb_valid = '0; s_cdb_id = '0; s_cdb_data = '0; s_cdb_jump = '0;
    s_cdb_tpc = '0; s_q1_id = '0; s_q2_id = '0;
  endtask

  task automatic set_cdb(int ch, int id, logic [31:0] d, bit j, logic [31:0] t);
    cdb_valid[ch] = 1'b1; cdb_id[ch*IDW +: IDW] = IDW'(id); cdb_data[ch*32 +: 32] = d;
    cdb_jump[ch] = j; cdb_tpc[ch*32 +: 32] = t;
  endtask

  task automatic do_reset();
    idle(); rdy = 1; rst = 1;
    tick(); tick();
    rst = 0;
  endtask

  task automatic alloc(int rd);
    idle(); alloc_en = 1; alloc_rd = 5'(rd); tick(); idle();
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (alloc_id !== IDW'(1)) begin n_err++; $display("FAIL reset_alloc_id: got %0d want 1", alloc_id); end
    n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", full); end
    n_vec++; if (cmt_valid !== '0 || cmt_rd !== '0 || cmt_id !== '0 || cmt_data !== '0) begin
      n_err++; $display("FAIL reset_cmt: valid %b rd %h id %h data %h want all 0", cmt_valid, cmt_rd, cmt_id, cmt_data); end
    n_vec++; if (flush !== 1'b0 || flush_pc !== 32'h0) begin
      n_err++; $display("FAIL reset_flush: flush %b pc %h want 0/0", flush, flush_pc); end
    n_vec++; if (s_alloc_id !== SIDW'(1) || s_full !== 1'b0) begin
      n_err++; $display("FAIL reset_small: alloc_id %0d full %b want 1/0", s_alloc_id, s_full); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    alloc(1);
    set_cdb(0, 1, 32'h33, 0, 0); tick(); idle();
    rst = 1; tick(); rst = 0;
    n_vec++; if (cmt_valid !== '0 || alloc_id !== IDW'(1)) begin
      n_err++; $display("FAIL reset_mid_cycle: cmt_valid %b alloc_id %0d want 0/1", cmt_valid, alloc_id); end
    tick();
    n_vec++; if (cmt_valid !== '0) begin n_err++; $display("FAIL reset_mid_after: cmt_valid %b want 0", cmt_valid); end
  endtask

  task automatic test_dual_commit();
    do_reset();
    alloc(3); alloc(4);
    n_vec++; if (alloc_id !== IDW'(3)) begin n_err++; $display("FAIL dual_alloc_id: got %0d want 3", alloc_id); end
    alloc(5);
    set_cdb(0, 2, 32'hA, 0, 0); tick(); idle();
    set_cdb(0, 1, 32'hB, 0, 0); tick(); idle();
    n_vec++; if (cmt_valid !== 2'b00) begin n_err++; $display("FAIL dual_early: cmt_valid %b want 00", cmt_valid); end
    tick();
    n_vec++; if (cmt_valid !== 2'b11) begin n_err++; $display("FAIL dual_valid: got %b want 11", cmt_valid); end
    n_vec++; if (cmt_id !== {5'd2, 5'd1}) begin n_err++; $display("FAIL dual_id: got %h want %h", cmt_id, {5'd2, 5'd1}); end
    n_vec++; if (cmt_data !== {32'hA, 32'hB}) begin n_err++; $display("FAIL dual_data: got %h want %h", cmt_data, {32'hA, 32'hB}); end
    n_vec++; if (cmt_rd !== {5'd4, 5'd3}) begin n_err++; $display("FAIL dual_rd: got %h want %h", cmt_rd, {5'd4, 5'd3}); end
    tick();
    n_vec++; if (cmt_valid !== 2'b00) begin n_err++; $display("FAIL dual_id3_held: cmt_valid %b want 00", cmt_valid); end
  endtask

  task automatic test_query();
    do_reset();
    alloc(1); alloc(2);
    set_cdb(0, 2, 32'h5, 0, 0); set_cdb(1, 2, 32'h7, 0, 0); q1_id = 5'd2; q2_id = 5'd0; #1;
    n_vec++; if (q1_ready !== 1'b1 || q1_data !== 32'h7) begin
      n_err++; $display("FAIL query_bypass: ready %b data %h want 1/7", q1_ready, q1_data); end
    n_vec++; if (q2_ready !== 1'b0 || q2_data !== 32'h0) begin
      n_err++; $display("FAIL query_id0: ready %b data %h want 0/0", q2_ready, q2_data); end
    tick(); idle();
    q1_id = 5'd2; q2_id = 5'd1; #1;
    n_vec++; if (q1_ready !== 1'b1 || q1_data !== 32'h7) begin
      n_err++; $display("FAIL query_stored: ready %b data %h want 1/7", q1_ready, q1_data); end
    n_vec++; if (q2_ready !== 1'b0) begin n_err++; $display("FAIL query_not_ready: ready %b want 0", q2_ready); end
    set_cdb(1, 1, 32'h9, 0, 0); #1;
    n_vec++; if (q2_ready !== 1'b1 || q2_data !== 32'h9) begin
      n_err++; $display("FAIL query_ch1: ready %b data %h want 1/9", q2_ready, q2_data); end
    idle();
  endtask

  task automatic test_flush();
    do_reset();
    alloc(1); alloc(2);
    set_cdb(0, 1, 32'h11, 1, 32'h100); set_cdb(1, 2, 32'h22, 0, 0); tick(); idle();
    tick();
    n_vec++; if (cmt_valid !== 2'b01 || cmt_id[IDW-1:0] !== IDW'(1)) begin
      n_err++; $display("FAIL flush_commit: valid %b id %0d want 01/1", cmt_valid, cmt_id[IDW-1:0]); end
    n_vec++; if (flush !== 1'b1 || flush_pc !== 32'h100) begin
      n_err++; $display("FAIL flush_strobe: flush %b pc %h want 1/100", flush, flush_pc); end
    alloc_en = 1; alloc_rd = 5'd9; set_cdb(0, 2, 32'h44, 0, 0);
    tick(); idle();
    n_vec++; if (flush !== 1'b0 || cmt_valid !== 2'b00) begin
      n_err++; $display("FAIL flush_clear: flush %b valid %b want 0/00", flush, cmt_valid); end
    n_vec++; if (alloc_id !== IDW'(1) || full !== 1'b0) begin
      n_err++; $display("FAIL flush_empty: alloc_id %0d full %b want 1/0", alloc_id, full); end
    q1_id = 5'd2; #1;
    n_vec++; if (q1_ready !== 1'b0) begin n_err++; $display("FAIL flush_query: ready %b want 0", q1_ready); end
    tick(); tick();
    n_vec++; if (cmt_valid !== 2'b00) begin n_err++; $display("FAIL flush_no_id2: valid %b want 00", cmt_valid); end
    idle();
  endtask

  task automatic test_hold();
    do_reset();
    alloc(1); alloc(2);
    set_cdb(0, 1, 32'h33, 0, 0); tick(); idle();
    for (int i = 0; i < 3; i++) begin
      rdy = 0; alloc_en = 1; alloc_rd = 5'd7;
      set_cdb(0, 1, 32'h44, 0, 0); set_cdb(1, 2, 32'h55, 0, 0);
      tick();
      n_vec++; if (cmt_valid !== 2'b00 || alloc_id !== IDW'(3)) begin
        n_err++; $display("FAIL hold_cycle%0d: valid %b alloc_id %0d want 00/3", i, cmt_valid, alloc_id); end
    end
    idle(); rdy = 1; q1_id = 5'd1; q2_id = 5'd2; #1;
    n_vec++; if (q1_ready !== 1'b1 || q1_data !== 32'h33 || q2_ready !== 1'b0) begin
      n_err++; $display("FAIL hold_state: q1 %b/%h q2 %b want 1/33 0", q1_ready, q1_data, q2_ready); end
    tick();
    n_vec++; if (cmt_valid !== 2'b01 || cmt_id[IDW-1:0] !== IDW'(1) || cmt_data[31:0] !== 32'h33) begin
      n_err++; $display("FAIL hold_resume: valid %b id %0d data %h want 01/1/33", cmt_valid, cmt_id[IDW-1:0], cmt_data[31:0]); end
    idle();
  endtask

  task automatic test_full_small();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      idle(); s_alloc_en = 1; s_alloc_rd = 5'(i + 1); tick();
      if (i == 1) begin
        n_vec++; if (s_full !== 1'b0) begin n_err++; $display("FAIL small_full2: got %b want 0", s_full); end
      end
      if (i == 2) begin
        n_vec++; if (s_full !== 1'b1 || s_alloc_id !== SIDW'(4)) begin
          n_err++; $display("FAIL small_full3: full %b alloc_id %0d want 1/4", s_full, s_alloc_id); end
      end
    end
    idle();
    n_vec++; if (s_alloc_id !== SIDW'(1) || s_full !== 1'b1) begin
      n_err++; $display("FAIL small_hard_full: alloc_id %0d full %b want 1/1", s_alloc_id, s_full); end
    s_cdb_valid = 1'b1; s_cdb_id = SIDW'(1); s_cdb_data = 32'h55; tick(); idle();
    s_alloc_en = 1; s_alloc_rd = 5'd9; tick();
    n_vec++; if (s_cmt_valid !== 1'b1 || s_cmt_id !== SIDW'(1) || s_cmt_data !== 32'h55) begin
      n_err++; $display("FAIL small_commit: valid %b id %0d data %h want 1/1/55", s_cmt_valid, s_cmt_id, s_cmt_data); end
    n_vec++; if (s_alloc_id !== SIDW'(1) || s_full !== 1'b1) begin
      n_err++; $display("FAIL small_fifth_ignored: alloc_id %0d full %b want 1/1", s_alloc_id, s_full); end
    tick();
    n_vec++; if (s_alloc_id !== SIDW'(2) || s_full !== 1'b1 || s_cmt_valid !== 1'b0) begin
      n_err++; $display("FAIL small_realloc: alloc_id %0d full %b valid %b want 2/1/0", s_alloc_id, s_full, s_cmt_valid); end
    idle();
  endtask

  task automatic test_wrap();
    int prev, exp_id, ncm;
    do_reset();
    prev = 0; exp_id = 1; ncm = 0;
    for (int i = 0; i < D + 4; i++) begin
      idle();
      if (i < D + 3) begin
        alloc_en = 1; alloc_rd = 5'(i); #1;
        n_vec++; if (alloc_id !== IDW'(i % D + 1)) begin
          n_err++; $display("FAIL wrap_alloc_id%0d: got %0d want %0d", i, alloc_id, i % D + 1); end
      end
      if (prev != 0) set_cdb(0, prev, 32'(i), 0, 0);
      prev = (i < D + 3) ? i % D + 1 : 0;
      tick();
      for (int k = 0; k < CW; k++)
        if (cmt_valid[k]) begin
          n_vec++; if (cmt_id[k*IDW +: IDW] !== IDW'(exp_id)) begin
            n_err++; $display("FAIL wrap_order: got %0d want %0d", cmt_id[k*IDW +: IDW], exp_id); end
          exp_id = exp_id % D + 1; ncm++;
        end
    end
    idle();
    for (int t = 0; t < 10 && ncm < D + 3; t++) begin
      tick();
      for (int k = 0; k < CW; k++)
        if (cmt_valid[k]) begin
          n_vec++; if (cmt_id[k*IDW +: IDW] !== IDW'(exp_id)) begin
            n_err++; $display("FAIL wrap_order: got %0d want %0d", cmt_id[k*IDW +: IDW], exp_id); end
          exp_id = exp_id % D + 1; ncm++;
        end
    end
    n_vec++; if (ncm != D + 3) begin n_err++; $display("FAIL wrap_count: got %0d want %0d", ncm, D + 3); end
  endtask

  task automatic test_random();
    logic [33:0] r1, r2;
    int tid;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      idle();
      rst = ($urandom_range(0, 149) == 0);
      rdy = ($urandom_range(0, 7) != 0);
      alloc_en = $urandom_range(0, 1); alloc_rd = 5'($urandom);
      for (int c = 0; c < NC; c++)
        if ($urandom_range(0, 2) != 0) begin
          if (mq.size() > 0 && $urandom_range(0, 3) != 0) tid = mq[$urandom_range(0, mq.size() - 1)].id;
          else tid = $urandom_range(0, D);
          set_cdb(c, tid, $urandom, ($urandom_range(0, 24) == 0), $urandom);
        end
      q1_id = IDW'($urandom_range(0, D));
      q2_id = (mq.size() > 0) ? IDW'(mq[$urandom_range(0, mq.size() - 1)].id) : IDW'(0);
      #1;
      r1 = model_query(q1_id); r2 = model_query(q2_id);
      n_vec++; if (q1_ready !== r1[32] || (r1[33] && q1_data !== r1[31:0])) begin
        n_err++; $display("FAIL rnd_q1 id %0d: got %b/%h want %b/%h", q1_id, q1_ready, q1_data, r1[32], r1[31:0]); end
      n_vec++; if (q2_ready !== r2[32] || (r2[33] && q2_data !== r2[31:0])) begin
        n_err++; $display("FAIL rnd_q2 id %0d: got %b/%h want %b/%h", q2_id, q2_ready, q2_data, r2[32], r2[31:0]); end
      n_vec++; if (alloc_id !== IDW'(m_next_id) || full !== (mq.size() > D - FM)) begin
        n_err++; $display("FAIL rnd_alloc: id %0d full %b want %0d/%b", alloc_id, full, m_next_id, mq.size() > D - FM); end
      tick();
      n_vec++; if (cmt_valid !== m_cv) begin n_err++; $display("FAIL rnd_cmt_valid: got %b want %b", cmt_valid, m_cv); end
      for (int k = 0; k < CW; k++)
        if (m_cv[k]) begin
          n_vec++;
          if (cmt_id[k*IDW +: IDW] !== IDW'(m_id[k]) || cmt_rd[k*5 +: 5] !== m_rd[k] || cmt_data[k*32 +: 32] !== m_data[k]) begin
            n_err++; $display("FAIL rnd_cmt%0d: id %0d rd %0d data %h want %0d/%0d/%h", k, cmt_id[k*IDW +: IDW],
                              cmt_rd[k*5 +: 5], cmt_data[k*32 +: 32], m_id[k], m_rd[k], m_data[k]); end
        end
      n_vec++; if (flush !== m_flush || (m_flush && flush_pc !== m_flush_pc)) begin
        n_err++; $display("FAIL rnd_flush: got %b/%h want %b/%h", flush, flush_pc, m_flush, m_flush_pc); end
    end
    rst = 0; rdy = 1; idle();
  endtask

  initial begin
    rst = 1; rdy = 1; idle();
    test_reset();
    test_reset_mid();
    test_dual_commit();
    test_query();
    test_flush();
    test_hold();
    test_full_small();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/multi_port_rob.md
MULTI_PORT_ROB -- requirements
Module: multi_port_rob

Interface
REQ-001 Parameter DEPTH, default 16, entry count; power of two, 4..64.
REQ-002 Parameter NUM_CDB, default 2, number of writeback channels, 1..4.
REQ-003 Parameter COMMIT_W, default 2, maximum commits per cycle, 1..2.
REQ-004 Parameter FULL_MARGIN, default 2; full asserts when count > DEPTH - FULL_MARGIN.
REQ-005 Derived IDW = log2(DEPTH)+1. Entry id = slot index + 1; id 0 means "none".
REQ-006 clk  in  1  clock; reset rst, synchronous, active-high; clock clk.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 rdy  in  1  global enable; when 0, all state holds.
REQ-009 alloc_en  in  1  allocate one entry at tail.
REQ-010 alloc_rd  in  5  destination register; 0 means no writeback.
REQ-011 alloc_id  out  IDW  id the next allocation receives (tail+1), combinational.
REQ-012 full  out  1  occupancy above threshold, combinational from count.
REQ-013 cdb_valid  in  NUM_CDB  per-channel result valid.
REQ-014 cdb_id  in  NUM_CDB*IDW  per-channel target id, packed, channel 0 in LSBs.
REQ-015 cdb_data  in  NUM_CDB*32  per-channel result, packed.
REQ-016 cdb_jump  in  NUM_CDB  per-channel mispredict/redirect flag.
REQ-017 cdb_tpc  in  NUM_CDB*32  per-channel redirect target, packed.
REQ-018 q1_id, q2_id  in  IDW each  operand source queries.
REQ-019 q1_ready, q2_ready  out  1 each; q1_data, q2_data  out  32 each; combinational query replies.
REQ-020 cmt_valid  out  COMMIT_W  per-slot commit strobe, registered.
REQ-021 cmt_rd  out  COMMIT_W*5; cmt_id  out  COMMIT_W*IDW; cmt_data  out  COMMIT_W*32; all registered.
REQ-022 flush  out  1  registered redirect strobe; flush_pc  out  32  redirect target.

Function
REQ-023 Circular buffer with head, tail and count (width IDW). Empty: count==0; hard-full: count==DEPTH.
REQ-024 Allocation when alloc_en=1 and count<DEPTH: busy=1, ready=0, jump=0, data=0, rd=alloc_rd; tail advances modulo DEPTH. Allocation when count==DEPTH is ignored, even if a commit occurs in the same cycle.
REQ-025 CDB writes: for each channel with cdb_valid=1, id!=0 and target busy, set ready=1 and write data, jump and tpc. Two channels hitting one id in the same cycle: the higher channel index wins. A write to a non-busy id is ignored.
REQ-026 Commit, slot 0: head entry busy and ready.
REQ-027 Commit, slot 1 (COMMIT_W=2 only): requires slot 0 to commit, head+1 busy and ready, and head entry jump=0.
REQ-028 Each commit clears busy and ready, advances head and drives cmt_* on the next edge. cmt_valid for slots not committing is 0.
REQ-029 count_next = count + accepted_alloc - commits; all three may occur in one cycle.
REQ-030 A committing entry with jump=1 sets flush=1 and flush_pc=tpc on the same edge as its cmt_valid.
REQ-031 At the next edge with flush=1: all busy, ready and jump cleared; head=tail=count=0; cmt_valid=0; flush=0. alloc_en and CDB inputs in that cycle are ignored.
REQ-032 Query (applies to q1 and q2 alike), id 0: ready=0, data=0.
REQ-033 Query, otherwise: if any valid CDB channel targets the id this cycle, ready=1 and data is that channel's data (highest channel wins).
REQ-034 Query, no CDB match: reply with the stored ready and data.
REQ-035 Priority order: rst > flush > ~rdy hold > normal operation.

Reset
REQ-036 On rst: head=tail=count=0, all entries cleared, cmt_valid=0, cmt_rd=0, cmt_id=0, cmt_data=0, flush=0, flush_pc=0.
REQ-037 After rst: alloc_id=1, full=0.
REQ-038 Reset asserted mid-operation discards all in-flight entries. No commit is emitted in the reset cycle or the following cycle.

Verification
REQ-039 Allocate ids 1,2,3; CDB writes id2 then id1 (data 0xA, 0xB) -> cycle after id1 is ready: cmt_valid=2'b11, cmt_id={2,1}, cmt_data={0xA,0xB}; id3 does not commit.
REQ-040 DEPTH=4, FULL_MARGIN=2: three allocations -> full=1. Four allocations, then a fifth while a commit is pending -> fifth ignored, alloc_id unchanged.
REQ-041 Fill and drain DEPTH+3 entries -> ids wrap to 1 after DEPTH; commit order strictly sequential.
REQ-042 id1 receives jump=1, tpc=0x100; id2 ready -> single commit of id1, flush=1, flush_pc=0x100; next cycle count=0 and alloc_id=1; id2 is never committed.
REQ-043 q1_id=2 while channel 0 and channel 1 both write id2 (0x5, 0x7) -> q1_ready=1, q1_data=0x7 the same cycle; stored data=0x7.
REQ-044 rdy=0 for 3 cycles with pending CDB and alloc inputs -> no state change, no commits.
